// File: rtl/sv32_page_table_walker.sv
// Two-level SV32 page-table walker answering instruction-translation walk requests.
// Optional build macro: SV32_PTE_ACCESSED_CHECK_EN (leaf with A=0 is treated as a fault).
module sv32_page_table_walker (
    input  logic        clk,
    input  logic        resetn,
    input  logic        walk_valid,
    output logic        walk_ready,
    input  logic [31:0] address,
    input  logic [31:0] satp,
    output logic [31:0] pte,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [33:0] mem_addr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_L1,
        S_L0,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  vpn0_q, vpn0_d;
    logic        mem_valid_q, mem_valid_d;
    logic [33:0] mem_addr_q, mem_addr_d;
    logic [31:0] pte_q, pte_d;

    logic        p_v, p_r, p_w, p_x;
    logic        bad_perm, is_leaf, a_fault, misaligned;
    logic [21:0] mega_ppn, page_ppn;
    logic [33:0] root_ptr_addr, next_ptr_addr;
    logic        unused_ok;

    // Result is dropped to zero on any fault or when the page lies above 4 GiB.
    function automatic logic [31:0] make_pte(input logic [21:0] ppn,
                                             input logic [9:0]  flags,
                                             input logic        fault);
        if (fault || (ppn[21:20] != 2'b00)) begin
            return 32'h0;
        end
        return {ppn[19:0], 2'b00, flags};
    endfunction

    assign unused_ok = ^{address[11:0], satp[31:22]};

    assign p_v        = mem_rdata[0];
    assign p_r        = mem_rdata[1];
    assign p_w        = mem_rdata[2];
    assign p_x        = mem_rdata[3];
    assign bad_perm   = !p_v || (p_w && !p_r);
    assign is_leaf    = p_r || p_x;
    assign misaligned = (mem_rdata[19:10] != 10'd0);
    assign mega_ppn   = {mem_rdata[31:20], vpn0_q};
    assign page_ppn   = mem_rdata[31:10];

`ifdef SV32_PTE_ACCESSED_CHECK_EN
    assign a_fault = !mem_rdata[6];
`else
    assign a_fault = 1'b0;
`endif

    assign root_ptr_addr = {satp[21:0], 12'h000} + {22'd0, address[31:22], 2'b00};
    assign next_ptr_addr = {page_ppn, 12'h000} + {22'd0, vpn0_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        vpn0_d      = vpn0_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        pte_d       = pte_q;
        case (state_q)
            S_IDLE: begin
                if (walk_valid) begin
                    vpn0_d      = address[21:12];
                    mem_addr_d  = root_ptr_addr;
                    mem_valid_d = 1'b1;
                    state_d     = S_L1;
                end
            end
            S_L1: begin
                if (mem_ready) begin
                    if (bad_perm) begin
                        pte_d       = 32'h0;
                        mem_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end else if (is_leaf) begin
                        pte_d       = make_pte(mega_ppn, mem_rdata[9:0], misaligned || a_fault);
                        mem_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        // Pointer PTE: request stays up, only the address moves.
                        mem_addr_d = next_ptr_addr;
                        state_d    = S_L0;
                    end
                end
            end
            S_L0: begin
                if (mem_ready) begin
                    pte_d       = make_pte(page_ppn, mem_rdata[9:0],
                                           bad_perm || !is_leaf || a_fault);
                    mem_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 34'd0;
            pte_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            pte_q       <= pte_d;
        end
    end

    // VPN0 is pure datapath; it is always rewritten before use.
    always_ff @(posedge clk) begin
        vpn0_q <= vpn0_d;
    end

    assign walk_ready = (state_q == S_DONE);
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign pte        = pte_q;

endmodule

// File: doc/sv32_page_table_walker.md
Name: sv32_page_table_walker

Overview:
- Responder side of the instruction-translation walk handshake (walk_valid / walk_ready / pte).
- On each request it performs a two-level SV32 page-table walk through a single-beat 34-bit memory read port.
- It returns a flattened leaf: physical page base in bits 31:12, original PTE flags in bits 9:0.
- Any walk error returns an all-zero pte. The requester's permission checks (X=0) then raise the page fault.

Parameters:
- none

Ports:
- clk  in  1  system clock, single clock domain
- resetn  in  1  asynchronous, active-low reset
- walk_valid  in  1  walk request, level-sensitive
- walk_ready  out  1  one-cycle pulse: walk complete, pte valid
- address  in  32  virtual address; sampled when a walk is accepted
- satp  in  32  bits 21:0 = root PPN; sampled when a walk is accepted
- pte  out  32  flattened result; registered, held until the next completion
- mem_valid  out  1  memory read request
- mem_ready  in  1  memory read done; mem_rdata valid this cycle
- mem_addr  out  34  physical byte address of the PTE word
- mem_rdata  in  32  PTE read data

Behaviour:
- Reset (asynchronous, resetn low): state=IDLE, walk_ready=0, mem_valid=0, mem_addr=0, pte=0. Reset mid-walk aborts with no completion pulse. A pending mem_ready after reset is ignored.
- States and transitions:
  - IDLE: if walk_valid, latch VPN1=address[31:22], VPN0=address[21:12], root=satp[21:0]. Set mem_addr = {root,12'b0} + {VPN1,2'b00}, mem_valid=1, go to L1.
  - L1: hold mem_valid and mem_addr stable until mem_ready. On mem_ready, evaluate mem_rdata (p):
    - V=0, or (W=1 and R=0): fault.
    - Leaf (R or X set):
      - p[19:10] (PPN0) != 0: misaligned megapage, fault.
      - Otherwise PA base = {p[31:20], VPN0, 12'b0}, the 34-bit megapage base.
    - Non-leaf: mem_addr = {p[31:10],12'b0} + {VPN0,2'b00}, stay requesting, go to L0.
  - L0: same handshake. On mem_ready:
    - V=0, (W=1 and R=0), or non-leaf (R=X=0): fault.
    - Otherwise PA base = {p[31:10],12'b0}.
  - DONE: walk_ready=1 for exactly one cycle. pte register updated on entry to DONE. Next state IDLE.
- Result rules:
  - If PA base[33:32] != 0 (beyond 32-bit output space): fault.
  - Success: pte = {PA[31:12], 2'b00, p[9:0]}.
  - Fault: pte = 32'h0.
  - mem_valid deasserts in the cycle after the final mem_ready.
- Latency: best case walk_valid to walk_ready = 3 cycles for a megapage (IDLE, L1 with mem_ready, DONE). A 4 KiB page adds one cycle plus memory wait cycles.
- walk_valid in DONE is ignored.
- walk_valid deasserted mid-walk does not abort; the walk completes and pulses walk_ready.
- pte stays stable at least one cycle after walk_ready, because the requester samples it in the following cycle.
- Arithmetic: PTE addresses are 34-bit sums; no carry beyond bit 33.

Optional Feature:
- SV32_PTE_ACCESSED_CHECK_EN: when defined, a leaf with A=0 (bit 6) is a fault and pte=0. This is the Svade behaviour: software manages the A bit.
- When not defined, the A bit is ignored and copied through in pte[6].

Test Plan:
- satp=0x8008_0000, address=0x0040_1234, L1 rdata=0x2000_0401, L0 rdata=0x2004_8C4B -> mem_addr 0x0_8000_0004 then 0x0_8000_1004; pte=0x8012_304B; one walk_ready pulse.
- Same satp/address, L1 rdata=0x2010_004B (megapage) -> single read; pte=0x8040_104B; walk_ready 3 cycles after walk_valid when mem_ready is immediate.
- L1 rdata=0x2010_044B (misaligned megapage) -> pte=0x0000_0000; L1 rdata=0x0000_0000 (V=0) -> pte=0; L0 rdata=0x2004_8C01 (non-leaf at level 0) -> pte=0.
- mem_ready withheld 5 cycles -> mem_valid and mem_addr stable throughout; walk_ready only after mem_ready. Assert resetn low during L0 -> mem_valid=0 immediately, no walk_ready, next walk starts cleanly.
- With SV32_PTE_ACCESSED_CHECK_EN: L0 rdata=0x2004_8C0B (A=0) -> pte=0. Without the macro -> pte=0x8012_300B.
- walk_valid held high through DONE -> exactly one walk per acceptance; a new walk starts only from IDLE.
